// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone classic master: FSM states and default bus widths.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = WB_DATA_W / 8;

endpackage

// File: rtl/wishbone_master.sv
// Wishbone classic single-cycle initiator with a valid/ready command port and a one-cycle response strobe.
// Optional bus-wait timeout is enabled by defining WB_MASTER_TIMEOUT_EN.
module wishbone_master
  import wb_pkg::*;
#(
  parameter int ADDR_W  = WB_ADDR_W,
  parameter int DATA_W  = WB_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_W-1:0]     cmd_adr_i,
  input  logic [DATA_W-1:0]     cmd_dat_i,
  input  logic [DATA_W/8-1:0]   cmd_sel_i,
  output logic                  rsp_valid_o,
  output logic [DATA_W-1:0]     rsp_dat_o,
  output logic                  rsp_err_o,
  output logic [ADDR_W-1:0]     adr_o,
  output logic [DATA_W-1:0]     dat_o,
  input  logic [DATA_W-1:0]     dat_i,
  output logic                  we_o,
  output logic [DATA_W/8-1:0]   sel_o,
  output logic                  stb_o,
  output logic                  cyc_o,
  input  logic                  ack_i,
  input  logic                  err_i
);

  if ((DATA_W % 8) != 0) begin : g_bad_data_w
    $error("DATA_W must be a multiple of 8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  wb_state_e             state_q, state_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     adr_q, adr_d;
  logic [DATA_W-1:0]     dat_q, dat_d;
  logic [DATA_W/8-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0]     rsp_dat_q, rsp_dat_d;
  logic                  rsp_err_q, rsp_err_d;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]      tmo_cnt_q, tmo_cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
`ifdef WB_MASTER_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          sel_d   = cmd_sel_i;
          cyc_d   = 1'b1;
          state_d = BUS;
`ifdef WB_MASTER_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end

      BUS: begin
        // err_i wins over a simultaneous ack_i; any termination beats timeout expiry
        if (err_i) begin
          rsp_dat_d = '0;
          rsp_err_d = 1'b1;
          cyc_d     = 1'b0;
          state_d   = RESP;
        end else if (ack_i) begin
          rsp_dat_d = we_q ? '0 : dat_i;
          rsp_err_d = 1'b0;
          cyc_d     = 1'b0;
          state_d   = RESP;
        end
`ifdef WB_MASTER_TIMEOUT_EN
        else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
          if (tmo_cnt_d == CNT_W'(TIMEOUT)) begin
            rsp_dat_d = '0;
            rsp_err_d = 1'b1;
            cyc_d     = 1'b0;
            state_d   = RESP;
          end
        end
`endif
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;
  assign we_o        = we_q;
  assign sel_o       = sel_q;
  assign cyc_o       = cyc_q;
  assign stb_o       = cyc_q;

endmodule
